// File: rtl/debug_arb_pkg.sv
// Shared types and helpers for the debug slave access arbiter.
// Holds the FSM state encoding and a constant-width helper for counters and indices.
package debug_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Never returns less than 1 so single-entry ranges still get a real bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/debug_rr_pick.sv
// Combinational rotate-priority picker: the first asserted request at or after ptr wins.
// Produces a one-hot grant, the binary index of the winner and an any-request flag.
module debug_rr_pick
  import debug_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int k;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_slave_access_arbiter.sv
// Shares one Nios II debug_mem_slave among N debug requesters, one transaction at a time,
// with round-robin grant, optional ownership lock and a waitrequest watchdog.
module debug_slave_access_arbiter
  import debug_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int LOCK_IDLE = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ-1:0]         rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        m_address,
  output logic                     m_read,
  output logic                     m_write,
  output logic [DATA_W-1:0]        m_writedata,
  output logic                     m_debugaccess,
  input  logic [DATA_W-1:0]        m_readdata,
  input  logic                     m_waitrequest,
  output logic                     busy
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int WD_W  = clog2(TIMEOUT + 1);
  localparam int LK_W  = clog2(LOCK_IDLE + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [LK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] m_address_d;
  logic              m_read_d, m_write_d, m_debugaccess_d;
  logic [DATA_W-1:0] m_writedata_d;
  logic [N_REQ-1:0]  rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              busy_d;

  logic [N_REQ-1:0]  owner_mask;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              owner_lock;
  logic              owner_req;
  logic              release_now;

  // A requester still shows req_valid during its own completion pulse, so it is masked
  // out that cycle to avoid re-serving a request that has already been answered.
  assign owner_mask  = N_REQ'(1) << owner_q;
  assign owner_lock  = |(req_lock & owner_mask);
  assign owner_req   = |(req_valid & ~rsp_valid & owner_mask);
  assign release_now = lock_q && (!owner_lock || (lock_cnt_q == LK_W'(LOCK_IDLE)));
  assign eligible    = req_valid & ~rsp_valid &
                       ((lock_q && !release_now) ? owner_mask : {N_REQ{1'b1}});

  debug_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    lock_d          = lock_q;
    wd_cnt_d        = wd_cnt_q;
    lock_cnt_d      = lock_cnt_q;
    cap_d           = cap_q;
    err_d           = err_q;
    m_address_d     = m_address;
    m_read_d        = m_read;
    m_write_d       = m_write;
    m_writedata_d   = m_writedata;
    m_debugaccess_d = m_debugaccess;
    rsp_valid_d     = '0;
    rsp_err_d       = '0;
    rsp_rdata_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (lock_q) begin
          if (release_now) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
          end else if (owner_req) begin
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
        end
        if (pick_any) begin
          state_d         = ISSUE;
          owner_d         = pick_idx;
          wd_cnt_d        = '0;
          m_address_d     = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          m_writedata_d   = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          m_write_d       = req_write[pick_idx];
          m_read_d        = !req_write[pick_idx];
          m_debugaccess_d = 1'b1;
        end
      end

      ISSUE: begin
        if (!m_waitrequest) begin
          cap_d           = m_write ? '0 : m_readdata;
          err_d           = 1'b0;
          m_read_d        = 1'b0;
          m_write_d       = 1'b0;
          m_debugaccess_d = 1'b0;
          state_d         = RESP;
        end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          cap_d           = '0;
          err_d           = 1'b1;
          m_read_d        = 1'b0;
          m_write_d       = 1'b0;
          m_debugaccess_d = 1'b0;
          state_d         = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end

      RESP: begin
        rsp_valid_d = owner_mask;
        rsp_err_d   = err_q ? owner_mask : '0;
        rsp_rdata_d = cap_q;
        lock_d      = owner_lock && !err_q;
        lock_cnt_d  = '0;
        if (!lock_d) begin
          ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || lock_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= '0;
      lock_q        <= 1'b0;
      wd_cnt_q      <= '0;
      lock_cnt_q    <= '0;
      cap_q         <= '0;
      err_q         <= 1'b0;
      m_address     <= '0;
      m_read        <= 1'b0;
      m_write       <= 1'b0;
      m_writedata   <= '0;
      m_debugaccess <= 1'b0;
      rsp_valid     <= '0;
      rsp_err       <= '0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      lock_q        <= lock_d;
      wd_cnt_q      <= wd_cnt_d;
      lock_cnt_q    <= lock_cnt_d;
      cap_q         <= cap_d;
      err_q         <= err_d;
      m_address     <= m_address_d;
      m_read        <= m_read_d;
      m_write       <= m_write_d;
      m_writedata   <= m_writedata_d;
      m_debugaccess <= m_debugaccess_d;
      rsp_valid     <= rsp_valid_d;
      rsp_err       <= rsp_err_d;
      rsp_rdata     <= rsp_rdata_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_debug_slave_access_arbiter.sv
// Scoreboard bench for debug_slave_access_arbiter: directed requests push expected completions,
// an independent monitor pops and compares them whenever a completion pulse appears.
module tb_debug_slave_access_arbiter;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT   = 8;
  localparam int LOCK_IDLE = 20;

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_err;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [ADDR_W-1:0]       m_address;
  logic                    m_read;
  logic                    m_write;
  logic [DATA_W-1:0]       m_writedata;
  logic                    m_debugaccess;
  logic [DATA_W-1:0]       m_readdata;
  logic                    m_waitrequest;
  logic                    busy;

  exp_t sb[$];
  int   checks;
  int   errors;

  debug_slave_access_arbiter #(
    .N_REQ     (N_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .TIMEOUT   (TIMEOUT),
    .LOCK_IDLE (LOCK_IDLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_debugaccess (m_debugaccess),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .busy          (busy)
  );

  // Debug slave model: read data is a fixed tag OR'd with the word address.
  assign m_readdata = 32'hA5A5_0000 | 32'(m_address);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; requesters drop req_valid on the falling edge where their completion is visible.
  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~rsp_valid;
  endtask

  task automatic applyStimulus(input int i, input bit wr, input bit lk,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    req_write[i] = wr;
    req_lock[i]  = lk;
    req_addr[i*ADDR_W +: ADDR_W] = addr;
    req_wdata[i*DATA_W +: DATA_W] = data;
    req_valid[i] = 1'b1;
  endtask

  task automatic expectRsp(input int i, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.idx   = i;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic waitRsp(input int i, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (rsp_valid[i]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no completion for requester %0d within %0d cycles", name, i, budget);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (sb.size() == 0 && req_valid == '0 && !m_read && !m_write) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: still %0d pending, req_valid=%b, required drained", name, sb.size(), req_valid);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected response.
  initial begin
    exp_t        e;
    logic [3:0]  ev;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: rsp_valid=%b, required no completion", rsp_valid);
        end else begin
          e  = sb.pop_front();
          ev = 4'b0001 << e.idx;
          checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
          checkOutput("rsp_err", 32'(rsp_err), e.err ? 32'(ev) : 32'd0);
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int held;
    int cyc;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    req_valid     = '0;
    req_write     = '0;
    req_lock      = '0;
    req_addr      = '0;
    req_wdata     = '0;
    m_waitrequest = 1'b0;

    repeat (3) tick();
    checkOutput("reset_m_read", 32'(m_read), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] single read, zero wait states");
    applyStimulus(0, 1'b0, 1'b0, 9'h100, 32'h0);
    expectRsp(0, 1'b0, 32'hA5A5_0100);
    tick();
    checkOutput("t1_m_read", 32'(m_read), 32'd1);
    checkOutput("t1_m_write", 32'(m_write), 32'd0);
    checkOutput("t1_m_address", 32'(m_address), 32'h100);
    checkOutput("t1_debugaccess", 32'(m_debugaccess), 32'd1);
    tick();
    checkOutput("t1_cmd_drop", 32'(m_read), 32'd0);
    checkOutput("t1_no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("t1_rsp_latency", 32'(rsp_valid), 32'd1);
    waitIdle(10, "t1_drain");

    $display("[TB] four simultaneous reads, round robin from pointer 1");
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, 1'b0, 1'b0, 9'(9'h010 + i), 32'h0);
    expectRsp(1, 1'b0, 32'hA5A5_0011);
    expectRsp(2, 1'b0, 32'hA5A5_0012);
    expectRsp(3, 1'b0, 32'hA5A5_0013);
    expectRsp(0, 1'b0, 32'hA5A5_0010);
    waitIdle(40, "t2_drain");

    $display("[TB] locked owner served twice before waiting requester");
    applyStimulus(2, 1'b1, 1'b1, 9'h1A0, 32'hDEAD_BEEF);
    expectRsp(2, 1'b0, 32'h0);
    tick();
    checkOutput("t3_m_write", 32'(m_write), 32'd1);
    checkOutput("t3_m_writedata", m_writedata, 32'hDEAD_BEEF);
    waitRsp(2, 10, "t3_first");
    tick();
    checkOutput("t3_lock_busy", 32'(busy), 32'd1);
    applyStimulus(1, 1'b0, 1'b0, 9'h021, 32'h0);
    applyStimulus(2, 1'b0, 1'b1, 9'h022, 32'h0);
    expectRsp(2, 1'b0, 32'hA5A5_0022);
    expectRsp(1, 1'b0, 32'hA5A5_0021);
    waitRsp(2, 10, "t3_second");
    repeat (4) tick();
    checkOutput("t3_req1_blocked", 32'(m_read), 32'd0);
    checkOutput("t3_busy_locked", 32'(busy), 32'd1);
    req_lock[2] = 1'b0;
    waitRsp(1, 10, "t3_req1");
    tick();
    checkOutput("t3_unlocked_busy", 32'(busy), 32'd0);

    $display("[TB] watchdog abort with waitrequest stuck high");
    m_waitrequest = 1'b1;
    applyStimulus(3, 1'b0, 1'b1, 9'h033, 32'h0);
    expectRsp(3, 1'b1, 32'h0);
    tick();
    held = 0;
    for (int k = 0; k < 20 && m_read; k++) begin
      held++;
      tick();
    end
    checkOutput("t4_cmd_held", 32'(held), 32'(TIMEOUT));
    waitRsp(3, 5, "t4_err");
    tick();
    checkOutput("t4_lock_released", 32'(busy), 32'd0);
    m_waitrequest = 1'b0;
    req_lock[3]   = 1'b0;

    $display("[TB] lock released after owner stays silent");
    applyStimulus(0, 1'b0, 1'b1, 9'h040, 32'h0);
    expectRsp(0, 1'b0, 32'hA5A5_0040);
    waitRsp(0, 10, "t5_owner");
    tick();
    applyStimulus(3, 1'b0, 1'b0, 9'h043, 32'h0);
    expectRsp(3, 1'b0, 32'hA5A5_0043);
    repeat (10) tick();
    checkOutput("t5_req3_blocked", 32'(m_read), 32'd0);
    checkOutput("t5_busy_locked", 32'(busy), 32'd1);
    cyc = 10;
    for (int k = 0; k < 40 && !m_read; k++) begin
      tick();
      cyc++;
    end
    checkOutput("t5_idle_release_window", 32'(cyc >= LOCK_IDLE - 2 && cyc <= LOCK_IDLE + 2), 32'd1);
    waitRsp(3, 10, "t5_req3");
    req_lock[0] = 1'b0;

    $display("[TB] reset during a stalled transfer");
    m_waitrequest = 1'b1;
    applyStimulus(1, 1'b0, 1'b1, 9'h061, 32'h0);
    tick();
    checkOutput("t6_issue", 32'(m_read), 32'd1);
    tick();
    reset     = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    tick();
    checkOutput("t6_m_read", 32'(m_read), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_no_rsp", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    $display("[TB] requester drops valid mid-transfer");
    applyStimulus(2, 1'b0, 1'b0, 9'h072, 32'h0);
    expectRsp(2, 1'b0, 32'hA5A5_0072);
    tick();
    tick();
    req_valid[2] = 1'b0;
    tick();
    m_waitrequest = 1'b0;
    waitRsp(2, 10, "t7_dropped");

    waitIdle(10, "final_drain");
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
